// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: single-outstanding cache read/write requests issued as single-beat AXI4 transactions
module cache_axi_bridge (
    input  logic         clk,
    input  logic         rst,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [127:0] ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [15:0]  wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    output logic [31:0]  araddr,
    output logic [2:0]   arsize,
    output logic [7:0]   arlen,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [127:0] rdata,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    input  logic [1:0]   rresp,
    output logic [31:0]  awaddr,
    output logic [2:0]   awsize,
    output logic [7:0]   awlen,
    output logic [1:0]   awburst,
    output logic         awvalid,
    input  logic         awready,
    output logic [127:0] wdata,
    output logic [15:0]  wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic         bvalid,
    output logic         bready,
    input  logic [1:0]   bresp
);
    typedef enum logic [2:0] {IDLE, AR, R, W, B} state_t;
    state_t state, state_n;
    logic aw_pend, w_pend;
    logic unused;

    function automatic logic [2:0] size_of(input logic [2:0] t);
        return t == 3'b000 ? 3'd0 : t == 3'b001 ? 3'd1 : t == 3'b010 ? 3'd2 : 3'd4;
    endfunction

    assign unused    = ^{rresp, bresp};
    assign arlen     = 8'd0;
    assign awlen     = 8'd0;
    assign arburst   = 2'b01;
    assign awburst   = 2'b01;
    assign wlast     = 1'b1;
    assign rd_rdy    = state == IDLE;
    assign wr_rdy    = state == IDLE && !rd_req;
    // Channel valids/readies are gated by rst so they drop in the reset cycle itself
    assign arvalid   = !rst && state == AR;
    assign rready    = !rst && state == R;
    assign awvalid   = !rst && state == W && aw_pend;
    assign wvalid    = !rst && state == W && w_pend;
    assign bready    = !rst && state == B;
    assign ret_valid = rready && rvalid;
    assign ret_last  = rready && rlast;
    assign ret_data  = rdata;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = rd_req ? AR : wr_req ? W : IDLE;
            AR:      state_n = arready ? R : AR;
            R:       state_n = rvalid && rlast ? IDLE : R;
            W:       state_n = (!aw_pend || awready) && (!w_pend || wready) ? B : W;
            B:       state_n = bvalid ? IDLE : B;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            araddr  <= '0;
            arsize  <= '0;
            awaddr  <= '0;
            awsize  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
        end else begin
            state <= state_n;
            if (rd_rdy && rd_req) begin
                araddr <= rd_addr;
                arsize <= size_of(rd_type);
            end
            if (wr_rdy && wr_req) begin
                awaddr  <= wr_addr;
                awsize  <= size_of(wr_type);
                wdata   <= wr_data;
                wstrb   <= wr_wstrb;
                aw_pend <= 1'b1;
                w_pend  <= 1'b1;
            end
            if (awvalid && awready) aw_pend <= 1'b0;
            if (wvalid && wready) w_pend <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb_cache_axi_bridge: directed and randomized transaction-level checks of cache_axi_bridge
module tb_cache_axi_bridge;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rd_req, rd_rdy, ret_valid, ret_last;
    logic [2:0]   rd_type, wr_type, arsize, awsize;
    logic [31:0]  rd_addr, wr_addr, araddr, awaddr;
    logic [127:0] ret_data, wr_data, rdata, wdata;
    logic         wr_req, wr_rdy;
    logic [15:0]  wr_wstrb, wstrb;
    logic [7:0]   arlen, awlen;
    logic [1:0]   arburst, awburst, rresp, bresp;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int checks = 0;
    int errors = 0;
    logic hold_wr = 1'b0;
    logic [2:0] size_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};

    cache_axi_bridge dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .araddr(araddr), .arsize(arsize), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready), .rresp(rresp),
        .awaddr(awaddr), .awsize(awsize), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle_inputs();
        rd_req  = 1'b0;
        rd_addr = $urandom;
        rd_type = 3'($urandom);
        wr_req  = hold_wr;
        if (!hold_wr) begin
            wr_addr  = $urandom;
            wr_type  = 3'($urandom);
            wr_wstrb = 16'($urandom);
            wr_data  = rand128();
        end
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rdata   = rand128();
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        rresp   = 2'($urandom);
        bresp   = 2'($urandom);
    endtask

    // Read: accept, ar_d stall cycles before arready, then nbeats with random rvalid gaps
    task automatic do_read(input logic [31:0] addr, input logic [2:0] t, input int ar_d, input int nbeats);
        @(negedge clk);
        idle_inputs();
        rd_req = 1'b1; rd_addr = addr; rd_type = t;
        #1;
        chk("rd_accept_rd_rdy", rd_rdy, 1);
        if (hold_wr) chk("rd_prio_wr_rdy", wr_rdy, 0);
        chk("rd_accept_arvalid", arvalid, 0);
        for (int i = 0; i <= ar_d; i++) begin
            @(negedge clk);
            idle_inputs();
            arready = (i == ar_d);
            #1;
            chk("ar_valid", arvalid, 1);
            chk("ar_addr", araddr, addr);
            chk("ar_size", arsize, size_tab[t]);
            chk("ar_len", arlen, 0);
            chk("ar_burst", arburst, 1);
            chk("ar_rd_rdy", rd_rdy, 0);
            chk("ar_wr_rdy", wr_rdy, 0);
            chk("ar_rready", rready, 0);
        end
        for (int b = 0; b < nbeats; b++) begin
            int g;
            g = $urandom_range(0, 2);
            for (int j = 0; j <= g; j++) begin
                @(negedge clk);
                idle_inputs();
                rvalid = (j == g);
                rlast  = (j == g) ? (b == nbeats - 1) : 1'($urandom);
                #1;
                chk("r_rready", rready, 1);
                chk("r_ret_valid", ret_valid, rvalid);
                chk("r_ret_last", ret_last, rlast);
                if (rvalid) chk("r_ret_data", ret_data, rdata);
                chk("r_arvalid", arvalid, 0);
                chk("r_rd_rdy", rd_rdy, 0);
                chk("r_wr_rdy", wr_rdy, 0);
            end
        end
    endtask

    // Write: accept, AW handshake at W-cycle aw_d, W at w_d, B after b_d waits
    task automatic do_write(input logic [31:0] addr, input logic [2:0] t, input logic [15:0] strb,
                            input logic [127:0] data, input int aw_d, input int w_d, input int b_d);
        int n;
        n = aw_d > w_d ? aw_d : w_d;
        @(negedge clk);
        idle_inputs();
        wr_req = 1'b1; wr_addr = addr; wr_type = t; wr_wstrb = strb; wr_data = data;
        #1;
        chk("wr_accept_wr_rdy", wr_rdy, 1);
        chk("wr_accept_rd_rdy", rd_rdy, 1);
        chk("wr_accept_awvalid", awvalid, 0);
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            idle_inputs();
            awready = (i == aw_d) ? 1'b1 : (i > aw_d) ? 1'($urandom) : 1'b0;
            wready  = (i == w_d) ? 1'b1 : (i > w_d) ? 1'($urandom) : 1'b0;
            #1;
            chk("w_awvalid", awvalid, i <= aw_d);
            chk("w_wvalid", wvalid, i <= w_d);
            chk("w_bready", bready, 0);
            chk("w_rd_rdy", rd_rdy, 0);
            chk("w_wr_rdy", wr_rdy, 0);
            if (i <= aw_d) begin
                chk("aw_addr", awaddr, addr);
                chk("aw_size", awsize, size_tab[t]);
                chk("aw_len", awlen, 0);
                chk("aw_burst", awburst, 1);
            end
            if (i <= w_d) begin
                chk("w_data", wdata, data);
                chk("w_strb", wstrb, strb);
                chk("w_last", wlast, 1);
            end
        end
        for (int j = 0; j <= b_d; j++) begin
            @(negedge clk);
            idle_inputs();
            bvalid = (j == b_d);
            #1;
            chk("b_bready", bready, 1);
            chk("b_awvalid", awvalid, 0);
            chk("b_wvalid", wvalid, 0);
            chk("b_rd_rdy", rd_rdy, 0);
        end
    endtask

    task automatic chk_after_reset(input string ctx);
        chk({ctx, "_rd_rdy"}, rd_rdy, 1);
        chk({ctx, "_arvalid"}, arvalid, 0);
        chk({ctx, "_awvalid"}, awvalid, 0);
        chk({ctx, "_wvalid"}, wvalid, 0);
        chk({ctx, "_rready"}, rready, 0);
        chk({ctx, "_bready"}, bready, 0);
        chk({ctx, "_ret_valid"}, ret_valid, 0);
        chk({ctx, "_araddr"}, araddr, 0);
        chk({ctx, "_arsize"}, arsize, 0);
        chk({ctx, "_awaddr"}, awaddr, 0);
        chk({ctx, "_awsize"}, awsize, 0);
        chk({ctx, "_wdata"}, wdata, 0);
        chk({ctx, "_wstrb"}, wstrb, 0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rvalid = 1'b0;
        rlast = 1'b0;
        #1;
        chk_after_reset("reset");
        chk("reset_wr_rdy", wr_rdy, 1);
        chk("reset_ret_last", ret_last, 0);
        chk("reset_arlen", arlen, 0);
        chk("reset_awlen", awlen, 0);
        chk("reset_arburst", arburst, 1);
        chk("reset_awburst", awburst, 1);
        chk("reset_wlast", wlast, 1);

        do_read(32'h1C00_0004, 3'b010, 0, 1);
        do_write(32'h0000_0010, 3'b010, 16'h00F0, 128'hDEADBEEF << 32, 3, 0, 1);

        hold_wr  = 1'b1;
        wr_addr  = 32'h0000_2000; wr_type = 3'b001; wr_wstrb = 16'h0003; wr_data = rand128();
        do_read(32'h0000_3000, 3'b000, 1, 1);
        hold_wr = 1'b0;
        do_write(32'h0000_2000, 3'b001, 16'h0003, 128'h1234, 0, 0, 0);

        do_read(32'h8000_0040, 3'b010, 10, 1);
        do_read(32'h4000_0100, 3'b100, 0, 2);

        // Reset while in R
        @(negedge clk); idle_inputs(); rd_req = 1'b1; rd_addr = 32'hABCD_0000; rd_type = 3'b100;
        @(negedge clk); idle_inputs(); arready = 1'b1;
        #1; chk("rstr_arvalid_pre", arvalid, 1);
        @(negedge clk); idle_inputs(); rst = 1'b1; rvalid = 1'b1;
        #1;
        chk("rstr_rready_now", rready, 0);
        chk("rstr_ret_valid_now", ret_valid, 0);
        @(negedge clk); idle_inputs(); rst = 1'b0;
        #1; chk_after_reset("rst_in_r");

        // Reset while in W
        @(negedge clk); idle_inputs(); wr_req = 1'b1; wr_addr = 32'h55AA_0000; wr_wstrb = 16'hFFFF;
        @(negedge clk); idle_inputs();
        #1; chk("rstw_awvalid_pre", awvalid, 1);
        @(negedge clk); idle_inputs(); rst = 1'b1;
        #1;
        chk("rstw_awvalid_now", awvalid, 0);
        chk("rstw_wvalid_now", wvalid, 0);
        @(negedge clk); idle_inputs(); rst = 1'b0;
        #1; chk_after_reset("rst_in_w");

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1)
                do_read($urandom, 3'($urandom), $urandom_range(0, 4), $urandom_range(1, 3));
            else
                do_write($urandom, 3'($urandom), 16'($urandom), rand128(),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk); idle_inputs();
                #1;
                chk("gap_rd_rdy", rd_rdy, 1);
                chk("gap_wr_rdy", wr_rdy, 1);
                chk("gap_arvalid", arvalid, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
